// File: rtl/load_unit_pkg.sv
// Shared encodings and helpers for the data-memory load unit.
// The alignment check helper is only referenced when LOAD_UNIT_ALIGN_CHECK_EN is defined.
package load_unit_pkg;

  // Access size encodings on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Legal memory read latency range
  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // True when the access is not naturally aligned, or the size is reserved
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane extraction and sign/zero extension of a memory read word.
// Low address bits below the access size are ignored, so unaligned requests are
// silently forced onto their natural boundary.
module load_align
  import load_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it to 32 bits
  always_comb begin
    case (addr_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      // Word and reserved size both return the full word
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: issues a word-aligned read, waits MEM_LAT cycles,
// extracts the addressed byte/halfword/word and returns it over a valid/ready response.
// Optional feature macro: LOAD_UNIT_ALIGN_CHECK_EN flags misaligned and reserved-size
// requests as errors (no memory access, rsp_err=1, rsp_data=0).
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("load_unit: MEM_LAT out of range");
  end

  // WAIT runs while the counter steps from MEM_LAT-1 down to 0
  localparam logic [1:0] LatLoad = 2'(MEM_LAT - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [1:0]  lsb_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        req_ready_q;
  logic        mem_rd_en_q;
  logic [31:0] mem_addr_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        req_err;
  logic [31:0] align_data;

`ifdef LOAD_UNIT_ALIGN_CHECK_EN
  assign req_err = misaligned(req_size, req_addr[1:0]);
  assign rsp_err = rsp_err_q;
`else
  assign req_err = 1'b0;
  assign rsp_err = 1'b0;
`endif

  load_align u_align (
    .rdata_i  (mem_rdata),
    .addr_i   (lsb_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (align_data)
  );

  // FSM with registered handshake and memory outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      lsb_q       <= 2'd0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
      req_ready_q <= 1'b1;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            lsb_q       <= req_addr[1:0];
            size_q      <= req_size;
            signed_q    <= req_signed;
            rsp_err_q   <= req_err;
            req_ready_q <= 1'b0;
            // Erroneous requests pass through ISSUE without strobing memory so that
            // their response appears one edge after acceptance.
            mem_rd_en_q <= ~req_err;
            if (!req_err) begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          mem_rd_en_q <= 1'b0;
          cnt_q       <= LatLoad;
          if (rsp_err_q) begin
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            rsp_data_q  <= align_data;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
